htpa_overlay_pipe: RTL and testbench
====================================

HTPA_OVERLAY_PIPE -- requirements
Module: htpa_overlay_pipe

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NT, 20: number of target slots.
- XW, 7: pixel X width.
- YW, 6: pixel Y width.
- OFFS, 2: box extension left of xo and above yo, in pixels.
- BORDER, 1: border thickness in pixels, range 1..4.
- BLINK_FRAMES, 8: frames per fire blink half-period; 0 disables blinking.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), clock and reset first; it uses one clock, and reset is asynchronous and active-high:
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high reset.
- frame_start, in, 1: single-cycle strobe at start of frame.
- pix_valid, in, 1: X/Y valid this cycle.
- X, in, XW: pixel column.
- Y, in, YW: pixel row.
- busy, in, NT: slot occupied.
- IN, in, NT*26: slot k at bits [26k+25:26k], fields xo[25:19] yo[18:13] xn[12:6] yn[5:0].
- firein, in, NT: slot flagged as fire.
- out_valid, out, 1: result valid.
- draw, out, 1: pixel on any box border.
- box_draw, out, 1: pixel inside any box.
- fire_draw, out, 1: pixel inside a visible fire box.
- fire, out, 1: any latched slot has fire.
- hit_id, out, $clog2(NT): lowest-index slot whose box contains the pixel.

Function
REQ-003 On frame_start the block SHALL copy busy, IN and firein into shadow registers; all pixel tests SHALL use only the shadow copies.
REQ-004 A pixel presented in the same cycle as frame_start SHALL be tested against the old shadow contents; the new contents SHALL apply from the next cycle.
REQ-005 Box containment for slot k SHALL be: sbusy[k] AND (X+OFFS >= xo) AND (X <= xn) AND (Y+OFFS >= yo) AND (Y <= yn).
- Sums SHALL be computed in XW+3 and YW+3 bits; there SHALL be no wrap-around.
- A slot with xo > xn+OFFS or yo > yn+OFFS SHALL never contain any pixel.
REQ-006 Border for slot k SHALL be: box containment AND any of the following:
- X+OFFS < xo+BORDER.
- X+BORDER > xn.
- Y+OFFS < yo+BORDER.
- Y+BORDER > yn.
REQ-007 Pipeline stage 1 SHALL register the per-slot contain, border and fire-contain vectors plus pix_valid.
REQ-008 Pipeline stage 2 SHALL register the OR-reductions and the priority encoding.
REQ-009 Output latency SHALL be exactly 2 cycles: pix_valid in cycle n yields out_valid in cycle n+2. The pipeline SHALL accept one pixel per cycle with no stalls.
REQ-010 When out_valid=0, the outputs draw, box_draw, fire_draw and hit_id SHALL be 0.
REQ-011 hit_id SHALL be the lowest index k with containment; it SHALL be 0 when box_draw=0.
REQ-012 The frame counter SHALL increment on each frame_start and wrap at BLINK_FRAMES-1.
- On wrap, blink_on SHALL toggle.
- With BLINK_FRAMES=0, blink_on SHALL be held at 1.
REQ-013 fire_draw SHALL be OR over k of (containment AND sfirein[k] AND blink_on).
REQ-014 fire SHALL be a registered OR of the shadow firein. It SHALL update 1 cycle after frame_start and be independent of pix_valid.
REQ-015 If frame_start occurs while pixels are in flight, those pixels SHALL complete using the table they were tested against (per REQ-004).

Reset
REQ-016 While reset=1 the following SHALL be cleared to 0: all shadow registers, pipeline registers, the frame counter and every output. blink_on SHALL be set to 1.
REQ-017 Reset asserted mid-frame SHALL discard in-flight pixels: out_valid=0 on the first clk edge after reset deasserts.
REQ-018 After reset no box SHALL be drawn until the first frame_start has latched busy.

Verification
REQ-019 NT=20, slot 0 with xo=10 yo=5 xn=20 yn=15, busy[0]=1, then frame_start, then pixel (8,3):
- Required response 2 cycles later: out_valid=1, box_draw=1, draw=1, hit_id=0.
- For pixel (15,10): box_draw=1, draw=0.
REQ-020 Slots 3 and 7 both contain pixel (12,12) -> hit_id=3 and box_draw=1.
- With busy[3] cleared and frame_start applied -> hit_id=7.
REQ-021 Pixel (127,63) with slot xn=127, yn=63, xo=126, yo=62 -> box_draw=1 and draw=1, with no false hit from arithmetic wrap on (0,0).
REQ-022 firein[2]=1 on a box containing the pixel, BLINK_FRAMES=2:
- fire=1 throughout.
- fire_draw=1 in frames 1-2, 0 in frames 3-4, 1 in frames 5-6.
REQ-023 frame_start coincident with pixel (5,5), where the old table contains it and the new one does not -> box_draw=1 for that pixel and 0 for the same pixel on the next cycle.
REQ-024 Reset pulsed while 2 pixels are in flight -> out_valid=0 and all outputs 0 after release, and no box is drawn until the next frame_start.

Source files
------------

// File: rtl/htpa_overlay_if.sv
// rtl/htpa_overlay_if.sv - pixel/table/result bundle for the overlay pipe
//
// Groups the frame strobe, the pixel coordinates, the target table and the
// overlay results. Modport slave is the pipe side and master is the driver side.
//   frame_start, pix_valid, X, Y   : frame strobe and pixel under test
//   busy, IN, firein               : target table (26 bits per slot)
//   out_valid, draw, box_draw,
//   fire_draw, fire, hit_id        : overlay results, 2 cycles after the pixel
interface htpa_overlay_if #(
  parameter int NT = 20,
  parameter int XW = 7,
  parameter int YW = 6
);
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;

  logic             frame_start;
  logic             pix_valid;
  logic [XW-1:0]    X;
  logic [YW-1:0]    Y;
  logic [NT-1:0]    busy;
  logic [NT*26-1:0] IN;
  logic [NT-1:0]    firein;
  logic             out_valid;
  logic             draw;
  logic             box_draw;
  logic             fire_draw;
  logic             fire;
  logic [IW-1:0]    hit_id;

  modport master (
    output frame_start, pix_valid, X, Y, busy, IN, firein,
    input  out_valid, draw, box_draw, fire_draw, fire, hit_id
  );

  modport slave (
    input  frame_start, pix_valid, X, Y, busy, IN, firein,
    output out_valid, draw, box_draw, fire_draw, fire, hit_id
  );
endinterface

// File: rtl/htpa_overlay_pipe.sv
// rtl/htpa_overlay_pipe.sv - two-stage target box overlay test for a pixel stream
//
// Tests each pixel against a per-frame shadow copy of the target table and
// reports whether it lies inside a box, on a box border, or inside a blinking
// fire box, plus the lowest-index slot that contains it.
//   clk   : sole clock
//   reset : asynchronous, active-high reset
//   bus   : htpa_overlay_if slave (pixel in, table in, results out)
module htpa_overlay_pipe #(
  parameter int NT           = 20,
  parameter int XW           = 7,
  parameter int YW           = 6,
  parameter int OFFS         = 2,
  parameter int BORDER       = 1,
  parameter int BLINK_FRAMES = 8
) (
  input logic             clk,
  input logic             reset,
  htpa_overlay_if.slave   bus
);
  localparam int SW        = 26;
  localparam int IW        = (NT > 1) ? $clog2(NT) : 1;
  localparam int XS        = XW + 3;
  localparam int YS        = YW + 3;
  localparam int CW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CNT_MAX_I = (BLINK_FRAMES > 1) ? BLINK_FRAMES - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX  = CNT_MAX_I[CW-1:0];
  localparam logic [XS-1:0] X_OFFS   = XS'(OFFS);
  localparam logic [YS-1:0] Y_OFFS   = YS'(OFFS);
  localparam logic [XS-1:0] X_BORDER = XS'(BORDER);
  localparam logic [YS-1:0] Y_BORDER = YS'(BORDER);

  // Shadow table and blink state
  logic [NT-1:0]    r_sbusy;
  logic [NT-1:0]    r_sfire;
  logic [NT*SW-1:0] r_sin;
  logic [CW-1:0]    r_cnt;
  logic             r_blink_on;
  logic             r_in_frame;
  logic             r_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sbusy    <= '0;
      r_sfire    <= '0;
      r_sin      <= '0;
      r_cnt      <= '0;
      r_blink_on <= 1'b1;
      r_in_frame <= 1'b0;
      r_fire     <= 1'b0;
    end else if (bus.frame_start) begin
      r_sbusy    <= bus.busy;
      r_sfire    <= bus.firein;
      r_sin      <= bus.IN;
      r_fire     <= |bus.firein;
      r_in_frame <= 1'b1;
      // The stretch before the first frame_start is not a frame, so the
      // first strobe opens frame 1 without advancing the blink counter.
      if (BLINK_FRAMES > 0 && r_in_frame) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt      <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Per-slot tests; sums are widened so nothing wraps at the screen edge
  logic [XS-1:0] w_x, w_xp;
  logic [YS-1:0] w_y, w_yp;
  logic [NT-1:0] w_contain, w_border, w_fcontain;

  assign w_x  = XS'(bus.X);
  assign w_xp = w_x + X_OFFS;
  assign w_y  = YS'(bus.Y);
  assign w_yp = w_y + Y_OFFS;

  for (genvar k = 0; k < NT; k++) begin : g_slot
    logic [XS-1:0] w_xo, w_xn;
    logic [YS-1:0] w_yo, w_yn;
    logic          w_in;

    assign w_xo = XS'(r_sin[SW*k+19 +: XW]);
    assign w_yo = YS'(r_sin[SW*k+13 +: YW]);
    assign w_xn = XS'(r_sin[SW*k+6  +: XW]);
    assign w_yn = YS'(r_sin[SW*k    +: YW]);

    assign w_in = r_sbusy[k] && (w_xp >= w_xo) && (w_x <= w_xn)
                             && (w_yp >= w_yo) && (w_y <= w_yn);

    assign w_contain[k]  = w_in;
    assign w_border[k]   = w_in && ((w_xp < w_xo + X_BORDER) || (w_x + X_BORDER > w_xn) ||
                                    (w_yp < w_yo + Y_BORDER) || (w_y + Y_BORDER > w_yn));
    assign w_fcontain[k] = w_in && r_sfire[k] && r_blink_on;
  end

  // Stage 1: per-slot vectors, zeroed for idle cycles so stage 2 outputs 0
  logic          r_s1_valid;
  logic [NT-1:0] r_s1_contain, r_s1_border, r_s1_fcontain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_contain  <= '0;
      r_s1_border   <= '0;
      r_s1_fcontain <= '0;
    end else begin
      r_s1_valid    <= bus.pix_valid;
      r_s1_contain  <= bus.pix_valid ? w_contain  : '0;
      r_s1_border   <= bus.pix_valid ? w_border   : '0;
      r_s1_fcontain <= bus.pix_valid ? w_fcontain : '0;
    end
  end

  // Lowest set index wins; stays 0 when nothing is contained
  logic [IW-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int k = NT - 1; k >= 0; k--) begin
      if (r_s1_contain[k]) w_hit = IW'(k);
    end
  end

  // Stage 2: reductions and priority encode
  logic          r_out_valid, r_draw, r_box_draw, r_fire_draw;
  logic [IW-1:0] r_hit_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_draw      <= 1'b0;
      r_box_draw  <= 1'b0;
      r_fire_draw <= 1'b0;
      r_hit_id    <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_draw      <= |r_s1_border;
      r_box_draw  <= |r_s1_contain;
      r_fire_draw <= |r_s1_fcontain;
      r_hit_id    <= w_hit;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.draw      = r_draw;
  assign bus.box_draw  = r_box_draw;
  assign bus.fire_draw = r_fire_draw;
  assign bus.fire      = r_fire;
  assign bus.hit_id    = r_hit_id;
endmodule

// File: tb/tb_htpa_overlay_pipe.sv
// tb/tb_htpa_overlay_pipe.sv - self-checking bench for htpa_overlay_pipe
module tb_htpa_overlay_pipe;
  localparam int NT     = 20;
  localparam int XW     = 7;
  localparam int YW     = 6;
  localparam int OFFS   = 2;
  localparam int BORDER = 1;
  localparam int BF     = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  htpa_overlay_if #(.NT(NT), .XW(XW), .YW(YW)) u_if ();

  htpa_overlay_pipe #(
    .NT(NT), .XW(XW), .YW(YW), .OFFS(OFFS), .BORDER(BORDER), .BLINK_FRAMES(BF)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  typedef struct {
    int v;
    int d;
    int b;
    int f;
    int hit;
  } exp_t;

  exp_t exp_q[$];

  // t_*: table presented on the inputs; m_*: model's latched copy
  int t_busy[NT], t_fire[NT], t_xo[NT], t_yo[NT], t_xn[NT], t_yn[NT];
  int m_busy[NT], m_fire[NT], m_xo[NT], m_yo[NT], m_xn[NT], m_yn[NT];
  int m_nfs;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.v = 0; e.d = 0; e.b = 0; e.f = 0; e.hit = 0;
    return e;
  endfunction

  task automatic clear_table();
    for (int k = 0; k < NT; k++) begin
      t_busy[k] = 0; t_fire[k] = 0;
      t_xo[k] = 0; t_yo[k] = 0; t_xn[k] = 0; t_yn[k] = 0;
    end
  endtask

  task automatic set_slot(input int k, input int xo, input int yo, input int xn, input int yn,
                          input int fire);
    t_busy[k] = 1; t_fire[k] = fire;
    t_xo[k] = xo; t_yo[k] = yo; t_xn[k] = xn; t_yn[k] = yn;
  endtask

  task automatic load_table();
    for (int k = 0; k < NT; k++) begin
      u_if.busy[k]          = t_busy[k][0];
      u_if.firein[k]        = t_fire[k][0];
      u_if.IN[26*k+19 +: 7] = 7'(t_xo[k]);
      u_if.IN[26*k+13 +: 6] = 6'(t_yo[k]);
      u_if.IN[26*k+6  +: 7] = 7'(t_xn[k]);
      u_if.IN[26*k    +: 6] = 6'(t_yn[k]);
    end
  endtask

  // Blink: frame n (n-th frame_start since reset) shows fire for the first BF
  // frames, hides for the next BF, and so on; before any frame it is on.
  function automatic exp_t model_pix(input int pv, input int x, input int y);
    exp_t e;
    int   blink;
    int   c;
    e = zero_exp();
    blink = (m_nfs == 0) || ((((m_nfs - 1) / BF) % 2) == 0);
    if (pv == 0) return e;
    e.v = 1;
    for (int k = 0; k < NT; k++) begin
      c = (m_busy[k] != 0) && (x + OFFS >= m_xo[k]) && (x <= m_xn[k]) &&
          (y + OFFS >= m_yo[k]) && (y <= m_yn[k]);
      if (c != 0) begin
        if (e.b == 0) e.hit = k;
        e.b = 1;
        if ((x + OFFS < m_xo[k] + BORDER) || (x + BORDER > m_xn[k]) ||
            (y + OFFS < m_yo[k] + BORDER) || (y + BORDER > m_yn[k])) e.d = 1;
        if (m_fire[k] != 0 && blink != 0) e.f = 1;
      end
    end
    return e;
  endfunction

  function automatic int model_fire();
    int f;
    f = 0;
    for (int k = 0; k < NT; k++) if (m_fire[k] != 0) f = 1;
    return f;
  endfunction

  task automatic step(input string tag, input int fs, input int pv, input int x, input int y);
    exp_t e;
    load_table();
    u_if.frame_start = 1'(fs);
    u_if.pix_valid   = 1'(pv);
    u_if.X           = XW'(x);
    u_if.Y           = YW'(y);
    exp_q.push_back(model_pix(pv, x, y));
    if (fs != 0) begin
      for (int k = 0; k < NT; k++) begin
        m_busy[k] = t_busy[k]; m_fire[k] = t_fire[k];
        m_xo[k] = t_xo[k]; m_yo[k] = t_yo[k]; m_xn[k] = t_xn[k]; m_yn[k] = t_yn[k];
      end
      m_nfs++;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".out_valid"}, u_if.out_valid, e.v);
    check_eq({tag, ".draw"},      u_if.draw,      e.d);
    check_eq({tag, ".box_draw"},  u_if.box_draw,  e.b);
    check_eq({tag, ".fire_draw"}, u_if.fire_draw, e.f);
    check_eq({tag, ".hit_id"},    u_if.hit_id,    e.hit);
    check_eq({tag, ".fire"},      u_if.fire,      model_fire());
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    u_if.frame_start = 1'b0;
    u_if.pix_valid   = 1'b0;
    #1;
    check_eq({tag, ".rst_out_valid"}, u_if.out_valid, 0);
    check_eq({tag, ".rst_draw"},      u_if.draw,      0);
    check_eq({tag, ".rst_box_draw"},  u_if.box_draw,  0);
    check_eq({tag, ".rst_fire_draw"}, u_if.fire_draw, 0);
    check_eq({tag, ".rst_fire"},      u_if.fire,      0);
    check_eq({tag, ".rst_hit_id"},    u_if.hit_id,    0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NT; k++) begin
      m_busy[k] = 0; m_fire[k] = 0; m_xo[k] = 0; m_yo[k] = 0; m_xn[k] = 0; m_yn[k] = 0;
    end
    m_nfs = 0;
    exp_q.delete();
    exp_q.push_back(zero_exp());
  endtask

  task automatic random_table();
    for (int k = 0; k < NT; k++) begin
      t_busy[k] = int'($urandom_range(0, 1));
      t_fire[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      t_xo[k]   = int'($urandom_range(0, 127));
      t_yo[k]   = int'($urandom_range(0, 63));
      t_xn[k]   = clip(t_xo[k] + int'($urandom_range(0, 30)) - 5, 127);
      t_yn[k]   = clip(t_yo[k] + int'($urandom_range(0, 20)) - 5, 63);
    end
  endtask

  int fd_exp[6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    int s, px, py;
    u_if.frame_start = 1'b0;
    u_if.pix_valid   = 1'b0;
    u_if.X = '0; u_if.Y = '0; u_if.busy = '0; u_if.firein = '0; u_if.IN = '0;
    clear_table();
    #1;
    do_reset("init");

    // No box before the first frame_start, even with busy presented
    set_slot(0, 0, 0, 127, 63, 1);
    step("r18_px", 0, 1, 40, 20);
    step("r18_idle", 0, 0, 0, 0);
    check_eq("r18_box_lit", u_if.box_draw, 0);

    // Slot 0 box: corner pixel is on the border, centre pixel is not
    clear_table();
    set_slot(0, 10, 5, 20, 15, 0);
    step("r19_fs", 1, 0, 0, 0);
    step("r19_a", 0, 1, 8, 3);
    step("r19_b", 0, 1, 15, 10);
    check_eq("r19_a_valid_lit", u_if.out_valid, 1);
    check_eq("r19_a_box_lit",   u_if.box_draw,  1);
    check_eq("r19_a_draw_lit",  u_if.draw,      1);
    check_eq("r19_a_hit_lit",   u_if.hit_id,    0);
    step("r19_idle", 0, 0, 0, 0);
    check_eq("r19_b_box_lit",   u_if.box_draw,  1);
    check_eq("r19_b_draw_lit",  u_if.draw,      0);

    // Priority between overlapping slots 3 and 7
    clear_table();
    set_slot(3, 10, 10, 14, 14, 0);
    set_slot(7, 11, 11, 13, 13, 0);
    step("r20_fs", 1, 0, 0, 0);
    step("r20_px", 0, 1, 12, 12);
    step("r20_idle", 0, 0, 0, 0);
    check_eq("r20_hit3_lit", u_if.hit_id, 3);
    check_eq("r20_box_lit",  u_if.box_draw, 1);
    t_busy[3] = 0;
    step("r20_fs2", 1, 0, 0, 0);
    step("r20_px2", 0, 1, 12, 12);
    step("r20_idle2", 0, 0, 0, 0);
    check_eq("r20_hit7_lit", u_if.hit_id, 7);

    // Bottom-right corner: no wrap onto (0,0)
    clear_table();
    set_slot(5, 126, 62, 127, 63, 0);
    step("r21_fs", 1, 0, 0, 0);
    step("r21_corner", 0, 1, 127, 63);
    step("r21_origin", 0, 1, 0, 0);
    check_eq("r21_corner_box_lit",  u_if.box_draw, 1);
    check_eq("r21_corner_draw_lit", u_if.draw, 1);
    step("r21_idle", 0, 0, 0, 0);
    check_eq("r21_origin_box_lit",  u_if.box_draw, 0);

    // frame_start coincident with a pixel: old table applies to that pixel
    clear_table();
    set_slot(1, 0, 0, 10, 10, 0);
    step("r23_fs_old", 1, 0, 0, 0);
    clear_table();
    step("r23_px_fs", 1, 1, 5, 5);
    step("r23_px_new", 0, 1, 5, 5);
    check_eq("r23_old_box_lit", u_if.box_draw, 1);
    step("r23_idle", 0, 0, 0, 0);
    check_eq("r23_new_box_lit", u_if.box_draw, 0);

    // Fire blink across frames 1..6
    do_reset("r22");
    clear_table();
    set_slot(2, 25, 25, 40, 40, 1);
    for (int n = 1; n <= 6; n++) begin
      step("r22_fs", 1, 0, 0, 0);
      step("r22_px", 0, 1, 30, 30);
      step("r22_idle", 0, 0, 0, 0);
      check_eq($sformatf("r22_fire_f%0d", n), u_if.fire, 1);
      check_eq($sformatf("r22_fire_draw_f%0d", n), u_if.fire_draw, fd_exp[n-1]);
    end

    // Reset with two pixels in flight
    step("r24_p1", 0, 1, 30, 30);
    step("r24_p2", 0, 1, 31, 31);
    do_reset("r24");
    step("r24_after", 0, 1, 30, 30);
    check_eq("r24_valid_lit", u_if.out_valid, 0);
    step("r24_px_seen", 0, 0, 0, 0);
    check_eq("r24_nobox_lit", u_if.box_draw, 0);
    step("r24_fs", 1, 0, 0, 0);
    step("r24_px2", 0, 1, 30, 30);
    step("r24_idle", 0, 0, 0, 0);
    check_eq("r24_box_lit", u_if.box_draw, 1);

    // Randomized traffic against the model
    random_table();
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 59) random_table();
      if ($urandom_range(0, 1) == 0) begin
        s  = int'($urandom_range(0, NT - 1));
        px = clip(t_xo[s] + int'($urandom_range(0, 24)) - 4, 127);
        py = clip(t_yo[s] + int'($urandom_range(0, 16)) - 4, 63);
      end else begin
        px = int'($urandom_range(0, 127));
        py = int'($urandom_range(0, 63));
      end
      step("rnd", ($urandom_range(0, 11) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0, px, py);
    end
    step("rnd_drain1", 0, 0, 0, 0);
    step("rnd_drain2", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
